telemetry_uart_tx: RTL and testbench
====================================

TELEMETRY_UART_TX -- requirements
Module: telemetry_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the main clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port send, input, 1 bit: frame request, sampled every cycle.
REQ-006 The block SHALL have port pitch, input, 16 bits signed: pitch attitude word.
REQ-007 The block SHALL have port roll, input, 16 bits signed: roll attitude word.
REQ-008 The block SHALL have port yaw, input, 16 bits signed: yaw attitude word.
REQ-009 The block SHALL have port status, input, 8 bits: flight status byte.
REQ-010 The block SHALL have port TxD, output, 1 bit: UART serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit, registered: a frame is in progress.
REQ-012 The block SHALL have port frame_done, output, 1 bit, registered: one-cycle pulse when a frame completes.

Function
REQ-013 BIT_DIV SHALL equal CLK_FREQ/BAUD, truncated (434 at defaults); every start, data and stop bit SHALL last exactly BIT_DIV cycles.
REQ-014 A request SHALL be accepted on a rising edge where send=1 and busy=0; send while busy=1 SHALL be ignored with no queuing.
REQ-015 On acceptance, pitch, roll, yaw, status and the current sequence counter SHALL be latched; input changes during the frame SHALL have no effect.
REQ-016 Frame: 11 bytes in this order: 0xAA, 0x55, seq, pitch[15:8], pitch[7:0], roll[15:8], roll[7:0], yaw[15:8], yaw[7:0], status, checksum.
REQ-017 checksum SHALL be the 8-bit modulo-256 sum of bytes 3..10 (seq through status); carries SHALL be discarded.
REQ-018 Each byte SHALL be sent as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-019 Bytes SHALL be contiguous: the next start bit SHALL follow the previous stop bit with no gap.
REQ-020 FSM states SHALL be IDLE, START, DATA, STOP; transitions:
- IDLE->START on acceptance.
- START->DATA after BIT_DIV cycles.
- DATA->STOP after 8 bits.
- STOP->START if byte index < 10, else STOP->IDLE.
REQ-021 On acceptance at edge k, busy and TxD=0 SHALL appear from edge k+1.
REQ-022 busy SHALL stay high for exactly 110*BIT_DIV cycles (47740 at defaults).
REQ-023 At edge k+1+110*BIT_DIV, busy SHALL go 0 and frame_done SHALL be 1 for exactly that one cycle.
REQ-024 send=1 in the frame_done cycle SHALL be accepted, giving exactly one extra idle-high clock between frames.
REQ-025 The 8-bit seq counter SHALL increment by 1 per accepted frame and wrap from 0xFF to 0x00.
REQ-026 TxD SHALL be driven from a register (glitch-free); in IDLE, TxD=1.

Reset
REQ-027 While rst_n=0, the block SHALL force TxD=1, busy=0, frame_done=0, seq=0 and FSM=IDLE, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release the block SHALL restart in IDLE and never resume the partial frame.
REQ-029 The first edge after rst_n rises with send=1 SHALL be a normal acceptance.

Verification
REQ-030 Idle: release reset, send=0 for 1000 cycles -> TxD=1, busy=0, frame_done=0 throughout.
REQ-031 Single frame: pitch=0x1234, roll=0xFF00, yaw=0x0001, status=0x5A, first frame after reset -> bytes AA 55 00 12 34 FF 00 00 01 5A A0; each bit 434 cycles; frame_done 47741 edges after the acceptance edge.
REQ-032 Busy rejection: pulse send mid-frame and change the inputs -> current frame unchanged, no extra frame; next accepted frame carries seq=0x01.
REQ-033 Back-to-back: hold send=1 for 3 frames -> seq 00, 01, 02; one idle clock between frames; 256 frames -> seq wraps to 00.
REQ-034 Checksum wrap: seq=0x00, all payload bytes 0xFF -> checksum 0xF9.
REQ-035 Mid-frame reset during byte 5 -> TxD=1 and busy=0 while rst_n=0; next frame starts with seq=0x00 and a full AA 55 header.

Source files
------------

// File: rtl/telemetry_uart_tx.sv
// Attitude telemetry serialiser: latches one snapshot per request and sends an 11-byte
// framed packet (AA 55 seq payload checksum) over an 8N1 UART at BAUD bits per second.
module telemetry_uart_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               send,
  input  logic signed [15:0] pitch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic        [7:0]  status,
  output logic               TxD,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned BitDiv = CLK_FREQ / BAUD;
  localparam int unsigned CntW   = (BitDiv > 1) ? $clog2(BitDiv) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(BitDiv - 1);
  localparam logic [3:0]      LastByte = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      seq_lat_q, seq_lat_d;
  logic [15:0]     pitch_q, pitch_d;
  logic [15:0]     roll_q, roll_d;
  logic [15:0]     yaw_q, yaw_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      csum_q, csum_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            bit_end;
  logic [2:0]      next_bit;
  logic [7:0]      cur_byte;
  logic [7:0]      csum_in;

  assign accept   = send && !busy_q;
  assign bit_end  = (cnt_q == CntMax);
  assign next_bit = bit_idx_q + 3'd1;

  // Checksum is formed from the live inputs in the accepting cycle so it is ready with the snapshot.
  assign csum_in = seq_q + pitch[15:8] + pitch[7:0] + roll[15:8] + roll[7:0]
                 + yaw[15:8] + yaw[7:0] + status;

  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      4'd0:    cur_byte = 8'hAA;
      4'd1:    cur_byte = 8'h55;
      4'd2:    cur_byte = seq_lat_q;
      4'd3:    cur_byte = pitch_q[15:8];
      4'd4:    cur_byte = pitch_q[7:0];
      4'd5:    cur_byte = roll_q[15:8];
      4'd6:    cur_byte = roll_q[7:0];
      4'd7:    cur_byte = yaw_q[15:8];
      4'd8:    cur_byte = yaw_q[7:0];
      4'd9:    cur_byte = status_q;
      4'd10:   cur_byte = csum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    seq_d      = seq_q;
    seq_lat_d  = seq_lat_q;
    pitch_d    = pitch_q;
    roll_d     = roll_q;
    yaw_d      = yaw_q;
    status_d   = status_q;
    csum_d     = csum_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (accept) begin
          state_d    = StStart;
          cnt_d      = '0;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          seq_lat_d  = seq_q;
          seq_d      = seq_q + 8'd1;
          pitch_d    = pitch;
          roll_d     = roll;
          yaw_d      = yaw;
          status_d   = status;
          csum_d     = csum_in;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
          txd_d     = cur_byte[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            txd_d     = cur_byte[next_bit];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (byte_idx_q == LastByte) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_d    = StStart;
            byte_idx_d = byte_idx_q + 4'd1;
            txd_d      = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      seq_q      <= '0;
      seq_lat_q  <= '0;
      pitch_q    <= '0;
      roll_q     <= '0;
      yaw_q      <= '0;
      status_q   <= '0;
      csum_q     <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      seq_q      <= seq_d;
      seq_lat_q  <= seq_lat_d;
      pitch_q    <= pitch_d;
      roll_q     <= roll_d;
      yaw_q      <= yaw_d;
      status_q   <= status_d;
      csum_q     <= csum_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TxD        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Bench for telemetry_uart_tx: a serial-line decoder checks every byte against a queue of
// expected frames built from the stimulus; the main thread checks handshake timing.
module tb_telemetry_uart_tx;

  localparam int unsigned ClkFreq  = 250;
  localparam int unsigned Baud     = 100;
  localparam int unsigned BitDiv   = ClkFreq / Baud;
  localparam int unsigned FrameCyc = 110 * BitDiv;

  logic        clk;
  logic        rst_n;
  logic        send;
  logic [15:0] pitch;
  logic [15:0] roll;
  logic [15:0] yaw;
  logic [7:0]  status;
  logic        txd;
  logic        busy;
  logic        frame_done;

  telemetry_uart_tx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .pitch     (pitch),
    .roll      (roll),
    .yaw       (yaw),
    .status    (status),
    .TxD       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp;
  int          n_bad;
  logic [7:0]  exp_q[$];
  logic [7:0]  tb_seq;
  int          frames_rx;
  int          frames_exp;
  logic [7:0]  last_frame[11];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                            input logic [7:0] s);
    logic [7:0] b[11];
    logic [7:0] sum;
    b[0] = 8'hAA;    b[1] = 8'h55;    b[2] = tb_seq;
    b[3] = p[15:8];  b[4] = p[7:0];   b[5] = r[15:8];  b[6] = r[7:0];
    b[7] = y[15:8];  b[8] = y[7:0];   b[9] = s;
    sum = 8'h00;
    for (int i = 2; i < 10; i++) sum = sum + b[i];
    b[10] = sum;
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
    tb_seq = tb_seq + 8'd1;
    frames_exp++;
  endtask

  // Serial decoder: samples every falling edge, each bit must hold for exactly BitDiv samples.
  initial begin : monitor
    bit         m_active;
    bit         m_need_start;
    int         m_bit;
    int         m_cnt;
    int         m_idx;
    logic       m_level;
    logic       m_bad;
    logic [7:0] m_data;
    logic [7:0] m_frame[11];
    logic [7:0] e;
    m_active = 0; m_need_start = 0; m_bit = 0; m_cnt = 0; m_idx = 0;
    m_level = 1'b1; m_bad = 1'b0; m_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_active = 0; m_need_start = 0; m_idx = 0;
      end else begin
        if (!m_active && m_need_start) begin
          m_need_start = 0;
          check_eq("contiguous_start", txd, 1'b0);
          if (txd !== 1'b0) m_idx = 0;
        end
        if (!m_active && txd === 1'b0) begin
          m_active = 1; m_bit = 0; m_cnt = 0; m_bad = 1'b0;
        end
        if (m_active) begin
          if (m_cnt == 0) begin
            m_level = txd;
            if (m_bit >= 1 && m_bit <= 8) m_data[m_bit-1] = txd;
          end else if (txd !== m_level) begin
            m_bad = 1'b1;
          end
          m_cnt++;
          if (m_cnt == BitDiv) begin
            m_cnt = 0;
            m_bit++;
            if (m_bit == 10) begin
              m_active = 0;
              check_eq("bit_stable", m_bad, 1'b0);
              check_eq("stop_bit", m_level, 1'b1);
              check_eq("sb_has_data", 32'(exp_q.size() > 0), 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq($sformatf("byte%0d", m_idx), m_data, e);
              end
              m_frame[m_idx] = m_data;
              m_idx++;
              if (m_idx == 11) begin
                for (int i = 0; i < 11; i++) last_frame[i] = m_frame[i];
                frames_rx++;
                m_idx = 0;
              end else begin
                m_need_start = 1;
              end
            end
          end
        end
      end
    end
  end

  // Called at a falling edge with the DUT idle (or in its frame_done cycle).
  task automatic accept(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                        input logic [7:0] s, input bit hold);
    pitch = p; roll = r; yaw = y; status = s; send = 1'b1;
    push_frame(p, r, y, s);
    @(negedge clk);
    if (!hold) send = 1'b0;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_txd", txd, 1'b0);
  endtask

  // n counts falling edges after the acceptance edge; n == 1 on entry.
  task automatic wait_done(input int pulse_at);
    int n;
    int nbusy;
    n = 1;
    nbusy = (busy === 1'b1) ? 1 : 0;
    while (frame_done !== 1'b1 && n < int'(FrameCyc) + 50) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) nbusy++;
      if (pulse_at != 0 && n == pulse_at) begin
        send = 1'b1; pitch = ~pitch; roll = roll + 16'd1; yaw = 16'h8000; status = ~status;
      end
      if (pulse_at != 0 && n == pulse_at + 3) send = 1'b0;
    end
    check_eq("done_latency", n, FrameCyc + 1);
    check_eq("busy_cycles", nbusy, FrameCyc);
    check_eq("done_busy_low", busy, 1'b0);
    check_eq("done_txd_high", txd, 1'b1);
    check_eq("frames_rx", frames_rx, frames_exp);
  endtask

  task automatic run_b2b(input int nframes, input bit ff_at_zero);
    logic [15:0] p, r, y;
    logic [7:0]  s;
    for (int f = 0; f < nframes; f++) begin
      if (ff_at_zero && tb_seq == 8'h00) begin
        p = 16'hFFFF; r = 16'hFFFF; y = 16'hFFFF; s = 8'hFF;
      end else begin
        p = 16'($urandom); r = 16'($urandom); y = 16'($urandom); s = 8'($urandom);
      end
      accept(p, r, y, s, 1'b1);
      wait_done(0);
    end
    send = 1'b0;
    @(negedge clk);
    check_eq("b2b_release", busy, 1'b0);
  endtask

  initial begin : main
    int         bad;
    logic [7:0] golden[11];
    golden = '{8'hAA, 8'h55, 8'h00, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h5A, 8'hA0};
    n_cmp = 0; n_bad = 0; frames_rx = 0; frames_exp = 0; tb_seq = 8'h00;
    send = 1'b0; pitch = '0; roll = '0; yaw = '0; status = '0;
    rst_n = 1'b0;

    #12;
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);
    check_eq("idle_no_frames", frames_rx, 0);

    // Single reference frame.
    accept(16'h1234, 16'hFF00, 16'h0001, 8'h5A, 1'b0);
    wait_done(0);
    for (int i = 0; i < 11; i++) check_eq($sformatf("golden%0d", i), last_frame[i], golden[i]);
    @(negedge clk);
    check_eq("done_pulse_width", frame_done, 1'b0);

    // Requests and input changes mid-frame must not disturb or queue anything.
    accept(16'hA5A5, 16'h5A5A, 16'h0F0F, 8'hC3, 1'b0);
    wait_done(30 * BitDiv);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check_eq("no_queued_frame", bad, 0);
    check_eq("reject_seq", last_frame[2], 8'h01);

    run_b2b(3, 1'b0);
    check_eq("b2b_last_seq", last_frame[2], 8'h04);

    // Continue until the sequence counter wraps; the seq-0 frame carries an all-ones payload.
    run_b2b(252, 1'b1);
    check_eq("wrap_seq", last_frame[2], 8'h00);
    check_eq("wrap_payload", last_frame[3], 8'hFF);
    check_eq("wrap_checksum", last_frame[10], 8'hF9);

    // Abort a frame during byte 5.
    accept(16'h1111, 16'h2222, 16'h3333, 8'h44, 1'b0);
    repeat (50 * BitDiv + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    tb_seq = 8'h00;
    frames_exp = frames_rx;
    #1;
    check_eq("abort_txd", txd, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", frame_done, 1'b0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check_eq("abort_hold", bad, 0);
    pitch = 16'h0102; roll = 16'h0304; yaw = 16'h0506; status = 8'h07; send = 1'b1;
    push_frame(pitch, roll, yaw, status);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check_eq("post_rst_busy", busy, 1'b1);
    check_eq("post_rst_txd", txd, 1'b0);
    wait_done(0);
    check_eq("post_rst_hdr0", last_frame[0], 8'hAA);
    check_eq("post_rst_hdr1", last_frame[1], 8'h55);
    check_eq("post_rst_seq", last_frame[2], 8'h00);
    check_eq("post_rst_csum", last_frame[10], 8'h1C);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
